load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/rv_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared load/store codes, controller state encoding and an access-size helper
// for the load/store unit.
package rv_pkg;

    localparam logic [2:0] LD_LW  = 3'd1;
    localparam logic [2:0] LD_LB  = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // Access width in bytes; 0 means a store that never touches memory.
    function automatic logic [2:0] acc_bytes(input logic       load,
                                             input logic [2:0] ldtype,
                                             input logic [1:0] stsize);
        logic [2:0] r;
        r = 3'd4;
        if (load) begin
            case (ldtype)
                LD_LB, LD_LBU: r = 3'd1;
                LD_LH, LD_LHU: r = 3'd2;
                default:       r = 3'd4;
            endcase
        end else begin
            case (stsize)
                ST_SB:   r = 3'd1;
                ST_SH:   r = 3'd2;
                ST_SW:   r = 3'd4;
                ST_NONE: r = 3'd0;
                default: r = 3'd0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replicated write data, plus
// lane selection and sign/zero extension of load data.
module lsu_align
    import rv_pkg::*;
(
    input  logic [2:0]  i_ldtype,
    input  logic [1:0]  i_stsize,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_wdata;
        case (i_stsize)
            ST_SB: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            ST_SH: begin
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            ST_SW: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
            default: begin
                o_wstrb = 4'b0000;
                o_wdata = i_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_ldata = i_rdata;
        case (i_ldtype)
            LD_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
            LD_LH:   o_ldata = {{16{w_half[15]}}, w_half};
            LD_LBU:  o_ldata = {24'd0, w_byte};
            LD_LHU:  o_ldata = {16'd0, w_half};
            LD_LW:   o_ldata = i_rdata;
            default: o_ldata = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access with lane steering.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of aligning them.
//
// state  | meaning
// S_IDLE | ready for a new request
// S_REQ  | mem_req asserted, waiting for mem_gnt
// S_WAIT | load granted, waiting for mem_rvalid
// S_RESP | one-cycle completion pulse
module load_store_unit
    import rv_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_load,
    input  logic [2:0]    req_ldtype,
    input  logic [1:0]    req_stsize,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);

    lsu_state_e    r_state, w_next;
    logic          r_load;
    logic [2:0]    r_ldtype;
    logic [1:0]    r_stsize;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic [2:0]    w_bytes;
    logic          w_skip;
    logic          w_err;
    logic [AW-1:0] w_addr_al;
    logic          w_accept;
    logic          w_capture;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ldata;

    assign w_bytes = acc_bytes(req_load, req_ldtype, req_stsize);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_mis;
    assign w_mis     = ((w_bytes == 3'd2) && req_addr[0]) ||
                       ((w_bytes == 3'd4) && (req_addr[1:0] != 2'b00));
    assign w_skip    = (w_bytes == 3'd0) || w_mis;
    assign w_err     = w_mis;
    assign w_addr_al = req_addr;
`else
    assign w_skip = (w_bytes == 3'd0);
    assign w_err  = 1'b0;
    // Misaligned accesses are silently pulled down to natural alignment.
    always_comb begin
        w_addr_al = req_addr;
        if (w_bytes == 3'd4)
            w_addr_al[1:0] = 2'b00;
        else if (w_bytes == 3'd2)
            w_addr_al[0] = 1'b0;
    end
`endif

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_capture = r_load && mem_rvalid &&
                       (((r_state == S_REQ) && mem_gnt) || (r_state == S_WAIT));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = w_skip ? S_RESP : S_REQ;
            S_REQ:  if (mem_gnt) w_next = (!r_load || mem_rvalid) ? S_RESP : S_WAIT;
            S_WAIT: if (mem_rvalid) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_load   <= 1'b0;
            r_ldtype <= 3'd0;
            r_stsize <= 2'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_load   <= req_load;
                r_ldtype <= req_ldtype;
                r_stsize <= req_load ? ST_NONE : req_stsize;
                r_addr   <= w_addr_al;
                r_wdata  <= req_wdata;
                r_rdata  <= 32'd0;
                r_err    <= w_err;
            end else if (w_capture) begin
                r_rdata <= w_ldata;
            end
        end
    end

    lsu_align u_align (
        .i_ldtype  (r_ldtype),
        .i_stsize  (r_stsize),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_ldata   (w_ldata)
    );

    assign req_ready = (r_state == S_IDLE);
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = mem_req && !r_load;
    assign mem_addr  = {r_addr[AW-1:2], 2'b00};
    assign mem_wstrb = mem_we ? w_wstrb : 4'b0000;
    assign mem_wdata = w_wdata;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = rsp_valid && r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// traffic against a byte-level reference model.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load;
    logic [2:0]  req_ldtype;
    logic [1:0]  req_stsize;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.AW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_ldtype(req_ldtype), .req_stsize(req_stsize), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // observations from the last transaction
    int          obs_lat, obs_reqcnt;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we, obs_err, obs_unstable, obs_ready_bad, obs_accept_rdy, obs_after_ok;

    // model expectations
    bit          exp_acc, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;
    int          exp_lat;

    task automatic model(input bit ld, input logic [2:0] lt, input logic [1:0] ss,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int gd, input int rvd);
        int size, off;
        bit mis, sgn;
        logic [31:0] mask, v;
        if (ld) size = (lt == 2 || lt == 4) ? 1 : (lt == 3 || lt == 5) ? 2 : 4;
        else    size = (ss == 1) ? 1 : (ss == 2) ? 2 : (ss == 3) ? 4 : 0;
        mis = (size > 1) && ((addr % size) != 0);
        exp_addr = addr - (addr % 4);
        exp_wstrb = 4'b0000; exp_wdata = 32'd0; exp_rdata = 32'd0; exp_err = 1'b0;
        if (size == 0 || (TRAP && mis)) begin
            exp_acc = 1'b0;
            exp_err = TRAP && mis;
            exp_lat = 1;
        end else begin
            exp_acc = 1'b1;
            off = (addr % 4) - ((addr % 4) % size);
            exp_lat = 2 + gd + (ld ? rvd : 0);
            if (!ld) begin
                exp_wstrb = 4'(((1 << size) - 1) << off);
                if (size == 1)      exp_wdata = (wd & 32'hFF) * 32'h01010101;
                else if (size == 2) exp_wdata = (wd & 32'hFFFF) * 32'h00010001;
                else                exp_wdata = wd;
            end else begin
                mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 1);
                v = (rd >> (8 * off)) & mask;
                sgn = (lt == 2 || lt == 3) && v[8 * size - 1];
                exp_rdata = sgn ? (v | ~mask) : v;
            end
        end
    endtask

    // Issues one request and plays the memory side; records what the DUT did.
    task automatic run_txn(input bit ld, input logic [2:0] lt, input logic [1:0] ss,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int gd, input int rvd);
        int n, granted_at;
        bit granted;
        obs_lat = -1; obs_reqcnt = 0; obs_unstable = 0; obs_ready_bad = 0;
        obs_addr = 0; obs_wdata = 0; obs_wstrb = 0; obs_we = 0; obs_rdata = 0; obs_err = 0;
        obs_accept_rdy = req_ready;
        req_valid = 1; req_load = ld; req_ldtype = lt; req_stsize = ss;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0; req_load = 1'($urandom); req_ldtype = 3'($urandom);
        req_stsize = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        n = 1; granted = 0; granted_at = 0;
        while (n <= 40 && obs_lat < 0) begin
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (req_ready) obs_ready_bad = 1;
            if (rsp_valid) begin
                obs_lat = n; obs_rdata = rsp_rdata; obs_err = rsp_err;
            end else begin
                if (mem_req) begin
                    if (obs_reqcnt == 0) begin
                        obs_addr = mem_addr; obs_we = mem_we; obs_wstrb = mem_wstrb; obs_wdata = mem_wdata;
                    end else if (mem_addr !== obs_addr || mem_we !== obs_we ||
                                 mem_wstrb !== obs_wstrb || mem_wdata !== obs_wdata) begin
                        obs_unstable = 1;
                    end
                    obs_reqcnt++;
                    if (obs_reqcnt > gd) begin
                        mem_gnt = 1; granted = 1; granted_at = n;
                        if (ld && rvd == 0) begin mem_rvalid = 1; mem_rdata = rd; end
                    end
                end else if (granted && ld && n == granted_at + rvd) begin
                    mem_rvalid = 1; mem_rdata = rd;
                end
                @(posedge clk); #1;
                n++;
            end
        end
        mem_gnt = 0; mem_rvalid = 0;
        if (obs_lat >= 0) begin
            @(posedge clk); #1;
            obs_after_ok = !rsp_valid && req_ready;
        end else begin
            obs_after_ok = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 0; req_load = 0; req_ldtype = 0; req_stsize = 0;
        req_addr = 0; req_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({mem_req, mem_we, mem_wstrb, rsp_valid, rsp_err} !== 8'd0) begin
            n_err++; $display("FAIL reset_ctrl: got %b exp 0", {mem_req, mem_we, mem_wstrb, rsp_valid, rsp_err});
        end
        n_vec++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 96'd0) begin
            n_err++; $display("FAIL reset_data: addr %h wdata %h rdata %h exp 0", mem_addr, mem_wdata, rsp_rdata);
        end
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
        rst = 0;
    endtask

    task automatic test_store_directed();
        run_txn(0, 3'd0, 2'd3, 32'h100, 32'hDEADBEEF, 32'd0, 0, 0);
        n_vec++;
        if (obs_addr !== 32'h100 || obs_wstrb !== 4'b1111 || obs_wdata !== 32'hDEADBEEF || obs_we !== 1'b1) begin
            n_err++; $display("FAIL sw_mem: addr %h strb %b wdata %h we %b exp 100 1111 deadbeef 1",
                              obs_addr, obs_wstrb, obs_wdata, obs_we);
        end
        n_vec++;
        if (obs_lat !== 2) begin n_err++; $display("FAIL sw_latency: got %0d exp 2", obs_lat); end
        n_vec++;
        if (obs_rdata !== 32'd0 || obs_err !== 1'b0) begin
            n_err++; $display("FAIL sw_rsp: rdata %h err %b exp 0 0", obs_rdata, obs_err);
        end
        run_txn(0, 3'd0, 2'd1, 32'h103, 32'h000000AB, 32'd0, 0, 0);
        n_vec++;
        if (obs_wstrb !== 4'b1000 || obs_wdata[31:24] !== 8'hAB || obs_addr !== 32'h100) begin
            n_err++; $display("FAIL sb_lane3: strb %b byte %h addr %h exp 1000 ab 100",
                              obs_wstrb, obs_wdata[31:24], obs_addr);
        end
        run_txn(0, 3'd0, 2'd0, 32'h204, 32'h12345678, 32'd0, 0, 0);
        n_vec++;
        if (obs_reqcnt !== 0 || obs_lat !== 1 || obs_err !== 1'b0) begin
            n_err++; $display("FAIL st_none: reqs %0d lat %0d err %b exp 0 1 0", obs_reqcnt, obs_lat, obs_err);
        end
    endtask

    task automatic test_load_directed();
        run_txn(1, 3'd2, 2'd0, 32'h102, 32'd0, 32'h12803456, 0, 2);
        n_vec++;
        if (obs_rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_sext: got %h exp ffffff80", obs_rdata); end
        n_vec++;
        if (obs_lat !== 4 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
            n_err++; $display("FAIL lb_access: lat %0d addr %h we %b exp 4 100 0", obs_lat, obs_addr, obs_we);
        end
        run_txn(1, 3'd4, 2'd0, 32'h102, 32'd0, 32'h12803456, 0, 2);
        n_vec++;
        if (obs_rdata !== 32'h00000080) begin n_err++; $display("FAIL lbu_zext: got %h exp 00000080", obs_rdata); end
        run_txn(1, 3'd1, 2'd0, 32'h40, 32'd0, 32'hCAFEF00D, 0, 0);
        n_vec++;
        if (obs_lat !== 2 || obs_rdata !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL lw_fast: lat %0d rdata %h exp 2 cafef00d", obs_lat, obs_rdata);
        end
    endtask

    task automatic test_gnt_stall();
        run_txn(1, 3'd3, 2'd0, 32'h002, 32'd0, 32'h8001_7FFF, 3, 1);
        n_vec++;
        if (obs_reqcnt !== 4 || obs_unstable !== 1'b0 || obs_addr !== 32'h0) begin
            n_err++; $display("FAIL gnt_stall_req: cycles %0d unstable %b addr %h exp 4 0 0",
                              obs_reqcnt, obs_unstable, obs_addr);
        end
        n_vec++;
        if (obs_ready_bad !== 1'b0) begin n_err++; $display("FAIL gnt_stall_ready: got ready while busy, exp 0"); end
        n_vec++;
        if (obs_rdata !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_upper: got %h exp ffff8001", obs_rdata); end
    endtask

    task automatic test_misalign();
        logic [31:0] e_rd;
        int e_reqs, e_lat;
        logic e_err;
`ifdef LSU_MISALIGN_TRAP_EN
        e_reqs = 0; e_lat = 1; e_err = 1'b1; e_rd = 32'd0;
`else
        e_reqs = 1; e_lat = 2; e_err = 1'b0; e_rd = 32'hFFFFABCD;
`endif
        run_txn(1, 3'd3, 2'd0, 32'h101, 32'd0, 32'h1234ABCD, 0, 0);
        n_vec++;
        if (obs_reqcnt !== e_reqs || obs_lat !== e_lat) begin
            n_err++; $display("FAIL lh_misalign_access: reqs %0d lat %0d exp %0d %0d", obs_reqcnt, obs_lat, e_reqs, e_lat);
        end
        n_vec++;
        if (obs_err !== e_err || obs_rdata !== e_rd) begin
            n_err++; $display("FAIL lh_misalign_rsp: err %b rdata %h exp %b %h", obs_err, obs_rdata, e_err, e_rd);
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        req_valid = 1; req_load = 1; req_ldtype = 3'd1; req_stsize = 0; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 0; mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        n_vec++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL abort_wait: req %b rsp %b ready %b exp 0 0 0", mem_req, rsp_valid, req_ready);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            mem_rvalid = 0;
            if (rsp_valid || mem_req) seen = 1;
        end
        n_vec++;
        if (seen !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL abort_stray_rvalid: activity %b ready %b rdata %h exp 0 1 0", seen, req_ready, rsp_rdata);
        end
    endtask

    task automatic test_random_traffic(input int cnt, input bit stall);
        bit ld;
        logic [2:0] lt;
        logic [1:0] ss;
        logic [31:0] addr, wd, rd;
        int gd, rvd;
        for (int i = 0; i < cnt; i++) begin
            ld = 1'($urandom); lt = 3'($urandom); ss = 2'($urandom);
            addr = $urandom_range(0, 4095); wd = $urandom; rd = $urandom;
            gd = stall ? $urandom_range(0, 3) : 0;
            rvd = stall ? $urandom_range(0, 3) : 0;
            model(ld, lt, ss, addr, wd, rd, gd, rvd);
            run_txn(ld, lt, ss, addr, wd, rd, gd, rvd);
            n_vec++;
            if (obs_lat !== exp_lat || obs_accept_rdy !== 1'b1) begin
                n_err++; $display("FAIL rnd_latency[%0d]: got %0d rdy %b exp %0d 1 (ld %b lt %0d ss %0d a %h)",
                                  i, obs_lat, obs_accept_rdy, exp_lat, ld, lt, ss, addr);
            end
            n_vec++;
            if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin
                n_err++; $display("FAIL rnd_rsp[%0d]: rdata %h err %b exp %h %b (ld %b lt %0d a %h rd %h)",
                                  i, obs_rdata, obs_err, exp_rdata, exp_err, ld, lt, addr, rd);
            end
            n_vec++;
            if ((obs_reqcnt != 0) !== exp_acc || (exp_acc && (obs_addr !== exp_addr || obs_we !== !ld ||
                 obs_wstrb !== exp_wstrb || (!ld && obs_wdata !== exp_wdata)))) begin
                n_err++; $display("FAIL rnd_mem[%0d]: reqs %0d addr %h we %b strb %b wd %h exp acc %b %h %b %h",
                                  i, obs_reqcnt, obs_addr, obs_we, obs_wstrb, obs_wdata, exp_acc, exp_addr, exp_wstrb, exp_wdata);
            end
            n_vec++;
            if (obs_after_ok !== 1'b1 || obs_ready_bad !== 1'b0 || obs_unstable !== 1'b0) begin
                n_err++; $display("FAIL rnd_handshake[%0d]: after_ok %b ready_bad %b unstable %b exp 1 0 0",
                                  i, obs_after_ok, obs_ready_bad, obs_unstable);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_random_traffic(30, 1'b0);
    endtask

    initial begin
        test_reset();
        test_store_directed();
        test_load_directed();
        test_gnt_stall();
        test_misalign();
        test_reset_abort();
        test_random_traffic(60, 1'b1);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
